// File: rtl/noc_pkg.sv
// Shared NoC types for the 2-to-1 merge arbiter.
// Used by noc_arb_mux_2to1 and noc_rr_arb2.
package noc_pkg;

  localparam int DATA_W_DEF = 16;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/noc_rr_arb2.sv
// Two-input round-robin arbiter with packet lock.
// state | meaning
// IDLE  | no packet in flight; grant by request, ties broken by r_ptr
// LOCK0 | input 0 owns the link until its tail is accepted
// LOCK1 | input 1 owns the link until its tail is accepted
module noc_rr_arb2
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] last,
  input  logic       accept,
  output logic       grant
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_ptr;
  logic       w_ptr_nxt;
  logic       w_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_grant     = r_ptr;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (req == 2'b01)      w_grant = 1'b0;
        else if (req == 2'b10) w_grant = 1'b1;
        else                   w_grant = r_ptr;
      end
      LOCK0:   w_grant = 1'b0;
      LOCK1:   w_grant = 1'b1;
      default: w_grant = r_ptr;
    endcase
    // A tail releases the link and hands priority to the other input.
    if (accept) begin
      if (last[w_grant]) begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = ~w_grant;
      end else begin
        w_state_nxt = w_grant ? LOCK1 : LOCK0;
      end
    end
  end

  assign grant = w_grant;

endmodule

// File: rtl/noc_arb_mux_2to1.sv
// NoC 2-to-1 merge: round-robin with packet lock, one registered output stage.
// Optional statistics counters enabled by defining NOC_ARB_STATS_EN.
module noc_arb_mux_2to1
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] data_0_i,
  input  logic              valid_0_i,
  input  logic              last_0_i,
  output logic              ready_0_o,
  input  logic [DATA_W-1:0] data_1_i,
  input  logic              valid_1_i,
  input  logic              last_1_i,
  output logic              ready_1_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              src_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  flit_cnt_0_o,
  output logic [CNT_W-1:0]  flit_cnt_1_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_src;
  logic              w_slot_free;
  logic              w_grant;
  logic              w_ready_0;
  logic              w_ready_1;
  logic              w_acc_0;
  logic              w_acc_1;
  logic              w_accept;

  assign w_slot_free = !r_valid || ready_i;
  assign w_ready_0   = !rst_i && enable_i && w_slot_free && !w_grant;
  assign w_ready_1   = !rst_i && enable_i && w_slot_free &&  w_grant;
  assign w_acc_0     = w_ready_0 && valid_0_i;
  assign w_acc_1     = w_ready_1 && valid_1_i;
  assign w_accept    = w_acc_0 || w_acc_1;

  noc_rr_arb2 u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    ({valid_1_i, valid_0_i}),
    .last   ({last_1_i, last_0_i}),
    .accept (w_accept),
    .grant  (w_grant)
  );

  // Load and drain may happen on the same edge, giving one flit per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_src   <= 1'b0;
    end else if (w_accept) begin
      r_data  <= w_grant ? data_1_i : data_0_i;
      r_last  <= w_grant ? last_1_i : last_0_i;
      r_src   <= w_grant;
      r_valid <= 1'b1;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign ready_0_o = w_ready_0;
  assign ready_1_o = w_ready_1;
  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign last_o    = r_last;
  assign src_o     = r_src;

`ifdef NOC_ARB_STATS_EN
  logic [CNT_W-1:0] r_flit_cnt_0;
  logic [CNT_W-1:0] r_flit_cnt_1;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating counters: they stop at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_flit_cnt_0 <= '0;
      r_flit_cnt_1 <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_acc_0 && (r_flit_cnt_0 != '1)) r_flit_cnt_0 <= r_flit_cnt_0 + 1'b1;
      if (w_acc_1 && (r_flit_cnt_1 != '1)) r_flit_cnt_1 <= r_flit_cnt_1 + 1'b1;
      if (r_valid && !ready_i && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign flit_cnt_0_o = r_flit_cnt_0;
  assign flit_cnt_1_o = r_flit_cnt_1;
  assign stall_cnt_o  = r_stall_cnt;
`else
  assign flit_cnt_0_o = '0;
  assign flit_cnt_1_o = '0;
  assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_noc_arb_mux_2to1.sv
// Scoreboard bench for noc_arb_mux_2to1: directed scenarios plus random traffic.
module tb_noc_arb_mux_2to1;

  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b1;
  logic [DW-1:0] data_0_i = '0;
  logic          valid_0_i = 1'b0;
  logic          last_0_i = 1'b0;
  logic          ready_0_o;
  logic [DW-1:0] data_1_i = '0;
  logic          valid_1_i = 1'b0;
  logic          last_1_i = 1'b0;
  logic          ready_1_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          last_o;
  logic          src_o;
  logic          ready_i = 1'b1;
  logic [CW-1:0] flit_cnt_0_o;
  logic [CW-1:0] flit_cnt_1_o;
  logic [CW-1:0] stall_cnt_o;

  noc_arb_mux_2to1 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .data_0_i(data_0_i), .valid_0_i(valid_0_i), .last_0_i(last_0_i), .ready_0_o(ready_0_o),
    .data_1_i(data_1_i), .valid_1_i(valid_1_i), .last_1_i(last_1_i), .ready_1_o(ready_1_o),
    .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .src_o(src_o), .ready_i(ready_i),
    .flit_cnt_0_o(flit_cnt_0_o), .flit_cnt_1_o(flit_cnt_1_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

`ifdef NOC_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream packet queues: {last, data}
  logic [DW:0] pend0[$];
  logic [DW:0] pend1[$];
  int gap_pct = 0;

  typedef struct { logic [DW-1:0] data; logic last; logic src; } exp_t;
  exp_t exp_q[$];

  // Reference model: link owner (-1 = free), round-robin pointer, output slot occupancy.
  int  m_lock = -1;
  bit  m_ptr = 0;
  bit  m_valid = 0;
  bit  m_init = 0;
  int  m_fc0 = 0, m_fc1 = 0, m_st = 0;
  bit  p_hold = 0;
  logic [DW-1:0] p_data;
  logic p_last, p_src;
  bit  p_in0 = 0, p_in1 = 0;
  logic [DW:0] p_f0, p_f1;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(negedge clk) begin : model
    int g;
    bit slot, er0, er1, acc0, acc1;
    exp_t e;
    if (m_init && !rst_i) begin
      chk("valid_o", valid_o, m_valid);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_flit: got data 0x%0h with empty scoreboard", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("data_o", data_o, e.data);
          chk("last_o", last_o, e.last);
          chk("src_o", src_o, e.src);
        end
      end
      chk("flit_cnt_0", flit_cnt_0_o, STATS ? m_fc0 : 0);
      chk("flit_cnt_1", flit_cnt_1_o, STATS ? m_fc1 : 0);
      chk("stall_cnt", stall_cnt_o, STATS ? m_st : 0);
      if (p_hold) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, p_data);
        chk("hold_last", last_o, p_last);
        chk("hold_src", src_o, p_src);
      end
      if (p_in0) chk("in0_stable", {valid_0_i, last_0_i, data_0_i}, {1'b1, p_f0});
      if (p_in1) chk("in1_stable", {valid_1_i, last_1_i, data_1_i}, {1'b1, p_f1});
    end
    p_hold = valid_o && !ready_i;
    p_data = data_o; p_last = last_o; p_src = src_o;
    p_f0 = {last_0_i, data_0_i};
    p_f1 = {last_1_i, data_1_i};
    p_in0 = valid_0_i && !ready_0_o && !rst_i;
    p_in1 = valid_1_i && !ready_1_o && !rst_i;
    if (rst_i) begin
      chk("rst_ready_0", ready_0_o, 0);
      chk("rst_ready_1", ready_1_o, 0);
      m_lock = -1; m_ptr = 0; m_valid = 0; m_init = 1;
      m_fc0 = 0; m_fc1 = 0; m_st = 0;
      p_hold = 0; p_in0 = 0; p_in1 = 0;
      exp_q.delete();
    end else if (m_init) begin
      slot = !m_valid || ready_i;
      if (m_lock >= 0)                g = m_lock;
      else if (valid_0_i && !valid_1_i) g = 0;
      else if (valid_1_i && !valid_0_i) g = 1;
      else                            g = int'(m_ptr);
      er0 = enable_i && slot && (g == 0);
      er1 = enable_i && slot && (g == 1);
      if (valid_0_i || valid_1_i || m_lock >= 0) begin
        chk("ready_0_o", ready_0_o, er0);
        chk("ready_1_o", ready_1_o, er1);
      end
      acc0 = er0 && valid_0_i;
      acc1 = er1 && valid_1_i;
      if (m_valid && !ready_i) m_st = sat(m_st);
      if (acc0 || acc1) begin
        e.data = acc1 ? data_1_i : data_0_i;
        e.last = acc1 ? last_1_i : last_0_i;
        e.src  = acc1;
        exp_q.push_back(e);
        m_valid = 1;
        if (acc0) m_fc0 = sat(m_fc0); else m_fc1 = sat(m_fc1);
        if (e.last) begin m_lock = -1; m_ptr = !acc1; end
        else m_lock = acc1 ? 1 : 0;
      end else if (ready_i) begin
        m_valid = 0;
      end
    end
  end

  // One clock of upstream driving: retire accepted flits, present the next ones.
  task automatic step();
    bit a0, a1;
    @(negedge clk);
    a0 = valid_0_i && ready_0_o;
    a1 = valid_1_i && ready_1_o;
    @(posedge clk);
    #1;
    if (a0) begin void'(pend0.pop_front()); valid_0_i = 1'b0; end
    if (a1) begin void'(pend1.pop_front()); valid_1_i = 1'b0; end
    if (!valid_0_i && pend0.size() > 0 && $urandom_range(99) >= gap_pct) begin
      {last_0_i, data_0_i} = pend0[0]; valid_0_i = 1'b1;
    end
    if (!valid_1_i && pend1.size() > 0 && $urandom_range(99) >= gap_pct) begin
      {last_1_i, data_1_i} = pend1[0]; valid_1_i = 1'b1;
    end
  endtask

  task automatic reset_pulse();
    rst_i = 1'b1;
    pend0.delete(); pend1.delete();
    valid_0_i = 1'b0; valid_1_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic push_pkt(input int src, input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      logic [DW:0] f;
      f = {(i == len - 1), base + DW'(i)};
      if (src == 0) pend0.push_back(f); else pend1.push_back(f);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || valid_0_i || valid_1_i || valid_o) && n < budget) begin
      step(); n++;
    end
    chk("drain_timeout", n < budget, 1);
  endtask

  initial begin
    #1;
    reset_pulse();
    // Single 3-flit packet from input 0
    pend0.push_back({1'b0, 16'h1111});
    pend0.push_back({1'b0, 16'h2222});
    pend0.push_back({1'b1, 16'h3333});
    drain(50);

    // Contention with single-flit packets: src alternates from 0
    reset_pulse();
    for (int i = 0; i < 6; i++) begin
      push_pkt(0, 1, 16'hA000 + 16'(i));
      push_pkt(1, 1, 16'hB000 + 16'(i));
    end
    drain(60);

    // Packet lock: 4-flit packet on 0 while 1 waits
    reset_pulse();
    push_pkt(0, 4, 16'hC000);
    push_pkt(1, 2, 16'hD000);
    drain(60);

    // Backpressure: hold output for 5 cycles
    reset_pulse();
    push_pkt(0, 1, 16'hABCD);
    push_pkt(0, 1, 16'hBEEF);
    step(); step();
    chk("bp_valid", valid_o, 1);
    ready_i = 1'b0;
    repeat (5) step();
    chk("bp_stall_cnt", stall_cnt_o, STATS ? 5 : 0);
    chk("bp_data_hold", data_o, 16'hABCD);
    chk("bp_ready_0", ready_0_o, 0);
    ready_i = 1'b1;
    drain(40);

    // Reset mid-packet from input 1
    reset_pulse();
    push_pkt(1, 4, 16'hE000);
    step(); step(); step();
    reset_pulse();
    chk("rst_valid_o", valid_o, 0);
    push_pkt(0, 1, 16'h0F00);
    push_pkt(1, 1, 16'h1F00);
    step();
    chk("post_rst_ready_0", ready_0_o, 1);
    chk("post_rst_ready_1", ready_1_o, 0);
    drain(40);

    // enable_i low during LOCK1
    reset_pulse();
    push_pkt(1, 4, 16'h5000);
    step(); step(); step();
    push_pkt(0, 1, 16'h6000);
    enable_i = 1'b0;
    repeat (3) begin
      step();
      chk("dis_ready_0", ready_0_o, 0);
      chk("dis_ready_1", ready_1_o, 0);
    end
    enable_i = 1'b1;
    drain(40);

    // Random traffic
    gap_pct = 30;
    for (int c = 0; c < 1500; c++) begin
      if (pend0.size() < 4 && $urandom_range(3) == 0)
        push_pkt(0, $urandom_range(1, 4), 16'($urandom));
      if (pend1.size() < 4 && $urandom_range(3) == 0)
        push_pkt(1, $urandom_range(1, 4), 16'($urandom));
      ready_i  = ($urandom_range(99) < 70);
      enable_i = ($urandom_range(99) < 90);
      if ($urandom_range(299) == 0) reset_pulse();
      else step();
    end
    ready_i = 1'b1;
    enable_i = 1'b1;
    gap_pct = 0;
    drain(200);
    step(); step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/noc_arb_mux_2to1.md
Name: noc_arb_mux_2to1

Overview:
- Merge point of the NOC: combines two 16-bit flit streams onto one output link. It is the return direction of the 1-to-2 demux.
- Round-robin arbitration with packet lock: once an input wins on a head flit, it keeps the link until its tail flit is accepted.
- Valid/ready handshake on all channels; one registered output stage gives full throughput of 1 flit/cycle.

Parameters:
- DATA_W, 16, flit width in bits.
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  when 0, no new flits are accepted; the output stage still drains.
- data_0_i  in  DATA_W  input 0 flit.
- valid_0_i  in  1  input 0 flit valid.
- last_0_i  in  1  input 0 tail-flit marker.
- ready_0_o  out  1  input 0 flit accepted this cycle when high with valid_0_i.
- data_1_i, valid_1_i, last_1_i, ready_1_o  same as above, for input 1.
- data_o  out  DATA_W  output flit (registered).
- valid_o  out  1  output flit valid (registered).
- last_o  out  1  output tail marker (registered).
- src_o  out  1  index of the input that sourced the current output flit.
- ready_i  in  1  downstream accepts the output flit.
- flit_cnt_0_o  out  CNT_W  flits accepted from input 0.
- flit_cnt_1_o  out  CNT_W  flits accepted from input 1.
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0.

Behaviour:
- Reset (sync, rst_i=1 at posedge):
  - valid_o=0, data_o=0, last_o=0, src_o=0.
  - FSM=IDLE, priority pointer=0, all counters=0.
  - ready_0_o and ready_1_o are forced to 0 while rst_i=1.
- Output slot: slot_free = !valid_o || ready_i.
- An input x is accepted on a cycle when valid_x_i && ready_x_o.
- ready_x_o (combinational) = enable_i && slot_free && (grant == x).
  - At most one ready_x_o is high in any cycle.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - If only one input is valid, grant goes to that input.
  - If both are valid, grant goes to the input selected by the priority pointer.
  - On accept with last=1: stay in IDLE; pointer becomes the other input.
  - On accept with last=0: go to LOCKx.
- LOCKx:
  - Grant is fixed to x; the other input gets ready=0 even when idle-valid.
  - On accept of x with last=1: go to IDLE; pointer becomes the other input (!x).
  - Gaps in valid_x_i during LOCKx hold the lock.
- Output register:
  - On accept: data_o/last_o/src_o load from the winner and valid_o becomes 1 at the next edge. Latency is 1 cycle.
  - Else if ready_i: valid_o becomes 0.
  - Drain and load in the same cycle are allowed (back-to-back flits).
- Backpressure: with valid_o=1 and ready_i=0, all outputs hold stable and both ready_x_o are 0.
- enable_i=0 mid-packet: the lock is retained; acceptance resumes when enable_i returns to 1.
- Reset mid-packet: the lock and the pending output flit are discarded; upstream resend is a system-level responsibility.
- Protocol rules (assert in bench):
  - valid_x_i, data_x_i and last_x_i are stable until accepted.
  - valid_o, data_o and last_o are stable while valid_o && !ready_i.

Optional Feature:
- Macro NOC_ARB_STATS_EN.
- Defined:
  - flit_cnt_x_o increments on each accept from input x.
  - stall_cnt_o increments on each cycle with valid_o && !ready_i.
  - All counters saturate at all-ones and clear on reset.
- Undefined: the three counter outputs are tied to 0 and no counter flops are synthesised.
- Ports are identical in both builds.

Decomposition:
- noc_pkg holds:
  - DATA_W default constant.
  - flit_t (data + last).
  - arb_state_e {IDLE, LOCK0, LOCK1}.
- Sub-module noc_rr_arb2 contains the FSM and pointer.
  - Inputs: req[1:0], last[1:0], accept, rst.
  - Output: grant.
- The top level holds the output register and the counters.

Test Plan:
- Single packet: input 0 sends 3 flits 0x1111/0x2222/0x3333 (last on the third), ready_i=1 -> data_o shows the same sequence on consecutive cycles, 1 cycle after each accept; src_o=0; last_o high only with 0x3333.
- Contention: both inputs present single-flit packets continuously, ready_i=1 -> output src alternates 0,1,0,1 starting with 0 after reset; 1 flit/cycle.
- Packet lock: input 0 sends a 4-flit packet while input 1 is valid throughout -> ready_1_o stays 0 until the tail from input 0 is accepted; the first input-1 flit appears on the output the cycle after input 0's tail appears.
- Backpressure: ready_i=0 for 5 cycles with valid_o=1 -> data_o holds, ready_0_o=ready_1_o=0; stall_cnt_o=5 with NOC_ARB_STATS_EN defined, 0 without.
- Reset mid-packet: rst_i pulsed after 2 of 4 flits from input 1 -> next cycle valid_o=0 and FSM=IDLE; input 0 can then win immediately (pointer=0).
- enable_i=0 during LOCK1 for 3 cycles -> no accepts and input 0 still blocked; after re-enable, input 1 resumes and completes its packet.
